// File: rtl/seven_segment_seconds_counter_if.sv
// Standard 8-in / 8-out / 8-bidir tile interface between the chip harness and a user tile.
// The harness drives the master side and the tile implements the slave side.
interface seven_segment_seconds_counter_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/seven_segment_seconds_counter.sv
// Seconds counter tile: a 24-bit prescaler advances a BCD digit shown on a seven-segment display.
// Optional macro SEG_DP_BLINK_EN toggles the decimal point on every digit advance.
module seven_segment_seconds_counter #(
    parameter int MAX_COUNT = 10_000_000
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    seven_segment_seconds_counter_if.slave       bus
);

    localparam logic [23:0] MAX_CMP = 24'(MAX_COUNT);

    logic [23:0] second_counter;
    logic [3:0]  digit;
    logic [23:0] compare;
    logic        advance;
    logic [6:0]  segments;
    logic        dp;

    // uio_in is deliberately ignored by this tile.
    logic unused_uio_in;
    assign unused_uio_in = &{1'b0, bus.uio_in};

    always_comb begin
        compare = MAX_CMP;
        if (bus.ui_in != 8'h00) begin
            compare = {6'b0, bus.ui_in, 10'b0};
        end
    end

    // >= rather than == so that lowering compare mid-count wraps on the next edge.
    assign advance = (second_counter >= (compare - 24'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            second_counter <= 24'd0;
            digit          <= 4'd0;
        end else if (bus.ena) begin
            if (advance) begin
                second_counter <= 24'd0;
                digit          <= (digit >= 4'd9) ? 4'd0 : digit + 4'd1;
            end else begin
                second_counter <= second_counter + 24'd1;
            end
        end
    end

`ifdef SEG_DP_BLINK_EN
    logic dp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_q <= 1'b0;
        end else if (bus.ena && advance) begin
            dp_q <= ~dp_q;
        end
    end

    assign dp = dp_q;
`else
    assign dp = 1'b0;
`endif

    always_comb begin
        segments = 7'h00;
        case (digit)
            4'd0: segments = 7'h3F;
            4'd1: segments = 7'h06;
            4'd2: segments = 7'h5B;
            4'd3: segments = 7'h4F;
            4'd4: segments = 7'h66;
            4'd5: segments = 7'h6D;
            4'd6: segments = 7'h7D;
            4'd7: segments = 7'h07;
            4'd8: segments = 7'h7F;
            4'd9: segments = 7'h6F;
            default: segments = 7'h00;
        endcase
    end

    assign bus.uo_out  = {dp, segments};
    assign bus.uio_out = {4'b0000, digit};
    assign bus.uio_oe  = 8'h0F;

endmodule

// File: tb/tb_seven_segment_seconds_counter.sv
// Bench for seven_segment_seconds_counter: directed phases push expected display changes,
// a monitor pops them whenever uo_out changes and checks value and cycle of arrival.
module tb_seven_segment_seconds_counter;

    logic clk;
    logic rst_n;
    int unsigned cyc;

    int total;
    int bad;

    // {cycle[31:0], uio_out[7:0], uo_out[7:0]}
    logic [47:0] exp_q[$];
    logic        mon_en;
    logic [7:0]  prev_uo;
    int unsigned c0;

    seven_segment_seconds_counter_if bus();

    seven_segment_seconds_counter #(
        .MAX_COUNT(1000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and cycle count
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cyc=%0d)", name, act, req, cyc);
        end
    endtask

    // k-th advance of a phase: digit k mod 10, dp toggled k times
    task automatic push_exp(input int unsigned at_cycle, input int k);
        logic dp;
        int   d;
        d  = k % 10;
`ifdef SEG_DP_BLINK_EN
        dp = k[0];
`else
        dp = 1'b0;
`endif
        exp_q.push_back({at_cycle, 4'b0000, 4'(d), dp, seg_of(d)});
    endtask

    task automatic wait_cyc(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    // Assert reset away from any edge, check outputs with no clock, then release with new settings.
    task automatic start_phase(input logic [7:0] ui, input logic en);
        mon_en = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("reset_uo_out", 32'(bus.uo_out), 32'h3F);
        check("reset_uio_out", 32'(bus.uio_out), 32'h00);
        check("uio_oe", 32'(bus.uio_oe), 32'h0F);
        @(negedge clk);
        @(negedge clk);
        bus.ui_in = ui;
        bus.ena   = en;
        rst_n     = 1'b1;
        c0        = cyc;
        mon_en    = 1'b1;
    endtask

    task automatic end_phase(input string name, input int unsigned last_cycle);
        wait_cyc(last_cycle);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: every change of uo_out must match the head of the expected queue.
    always @(negedge clk) begin
        logic [47:0] e;
        if (bus.uo_out !== prev_uo) begin
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_change cyc=%0d uo_out=%h", cyc, bus.uo_out);
                end else begin
                    e = exp_q.pop_front();
                    check("advance_cycle", cyc, e[47:16]);
                    check("uo_out", 32'(bus.uo_out), 32'(e[7:0]));
                    check("uio_out", 32'(bus.uio_out), 32'(e[15:8]));
                end
            end
            prev_uo = bus.uo_out;
        end
    end

    initial begin
        total       = 0;
        bad         = 0;
        cyc         = 0;
        mon_en      = 1'b0;
        prev_uo     = 8'h3F;
        rst_n       = 1'b0;
        bus.ena     = 1'b0;
        bus.ui_in   = 8'h00;
        bus.uio_in  = 8'hA5;

        // Nominal rate: full 0..9 sweep, wrap back to 0, then on to 3.
        start_phase(8'h00, 1'b1);
        for (int k = 1; k <= 13; k++) push_exp(c0 + 32'(1000 * k), k);
        end_phase("drain_nominal", c0 + 13500);

        // Override ui_in=1: 1024-cycle period (reset lands mid-count with digit 3 showing).
        start_phase(8'h01, 1'b1);
        for (int k = 1; k <= 3; k++) push_exp(c0 + 32'(1024 * k), k);
        end_phase("drain_ui1", c0 + 3500);

        // Override ui_in=2: 2048-cycle period.
        start_phase(8'h02, 1'b1);
        for (int k = 1; k <= 2; k++) push_exp(c0 + 32'(2048 * k), k);
        end_phase("drain_ui2", c0 + 4500);

        // Compare lowered mid-count: counter at 3000 when compare drops to 1024.
        start_phase(8'h04, 1'b1);
        push_exp(c0 + 4096, 1);
        push_exp(c0 + 7097, 2);
        push_exp(c0 + 8121, 3);
        push_exp(c0 + 9145, 4);
        wait_cyc(c0 + 7096);
        bus.ui_in = 8'h01;
        end_phase("drain_lowered", c0 + 9500);

        // ena low for 500 cycles delays the advance by exactly 500.
        start_phase(8'h00, 1'b1);
        push_exp(c0 + 1500, 1);
        push_exp(c0 + 2500, 2);
        wait_cyc(c0 + 300);
        bus.ena = 1'b0;
        wait_cyc(c0 + 800);
        bus.ena = 1'b1;
        end_phase("drain_ena", c0 + 2800);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
